gpio_io_bridge: RTL

- Board-side end of the CPU GPIO interface.
- Input path: synchronizes and debounces the board switches into the 32-bit word the CPU reads (feeds the CPU's instr_in).
- Output path: watches the CPU's 32-bit GPIO output register (instr_out), converts it to decimal with a sequential double-dabble engine, and drives eight active-low seven-segment displays.

---
 rtl/gpio_io_bridge.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_io_bridge.sv
// Board-side GPIO bridge: debounced switch word in, CPU output word shown in decimal on eight 7-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks the digits above the most significant nonzero digit.
module gpio_io_bridge #(
  parameter int SW_W            = 18,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     sw_word,
  input  logic [31:0]     gpio_word,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic [6:0]      hex4,
  output logic [6:0]      hex5,
  output logic [6:0]      hex6,
  output logic [6:0]      hex7,
  output logic            busy,
  output logic            overflow
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]        SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [55:0]       HEX_RESET = {{7{SEG_BLANK}}, SEG_ZERO};
`else
  localparam logic [55:0]       HEX_RESET = {8{SEG_ZERO}};
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Walk from the top digit down; once a digit is shown, every lower digit is shown too.
  function automatic logic [55:0] encode_digits(input logic [31:0] digits);
    logic [55:0] segs;
    logic        seen;
    segs = '0;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      if ((digits[i*4 +: 4] != 4'd0) || (i == 0)) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
`else
      seen = 1'b1;
`endif
      segs[i*7 +: 7] = seen ? seg7(digits[i*4 +: 4]) : SEG_BLANK;
    end
    return segs;
  endfunction

  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_db_cnt [SW_W];
  logic [31:0]      r_sw_word;

  state_t           r_state;
  logic [31:0]      r_last;
  logic [31:0]      r_bin;
  logic [39:0]      r_bcd;
  logic [4:0]       r_cnt;
  logic             r_busy;
  logic             r_ovf;
  logic [55:0]      r_hex;
  logic [39:0]      w_bcd_adj;

  // Two-flop synchronizer for the raw switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < SW_W; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == CNT_MAX) begin
            r_stable[i] <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered, zero-extended switch word for the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_word <= 32'd0;
    end else begin
      r_sw_word <= 32'(r_stable);
    end
  end

  // Double-dabble correction: nibbles of 5 or more get 3 added before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end else begin
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4];
      end
    end
  end

  // Conversion FSM: capture on change, 32 shifts, then load the displays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 32'd0;
      r_bin   <= 32'd0;
      r_bcd   <= 40'd0;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_hex   <= HEX_RESET;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (gpio_word != r_last) begin
            r_bin   <= gpio_word;
            r_last  <= gpio_word;
            r_bcd   <= 40'd0;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[38:0], r_bin, 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_hex   <= encode_digits(r_bcd[31:0]);
          r_ovf   <= (r_bcd[39:32] != 8'd0);
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sw_word  = r_sw_word;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign hex0     = r_hex[6:0];
  assign hex1     = r_hex[13:7];
  assign hex2     = r_hex[20:14];
  assign hex3     = r_hex[27:21];
  assign hex4     = r_hex[34:28];
  assign hex5     = r_hex[41:35];
  assign hex6     = r_hex[48:42];
  assign hex7     = r_hex[55:49];

endmodule
